// File: rtl/register_file_16_pkg.sv
// Shared CPU constants: datapath width and register-file geometry.
// The bus mux and ALU import the same values, so all three agree on widths.
package register_file_16_pkg;

    localparam int CPU_DATA_W   = 16;
    localparam int CPU_NUM_REGS = 8;
    localparam int CPU_ADDR_W   = 3;

    localparam int                  WR_CNT_W   = 8;
    localparam logic [WR_CNT_W-1:0] WR_CNT_MAX = '1;

endpackage

// File: rtl/register_file_16.sv
// Register file: two combinational read ports and one write port. r0 is hardwired to zero.
// A write to the address being read appears on that read port in the same cycle.
module register_file_16
    import register_file_16_pkg::*;
#(
    parameter int DATA_W   = CPU_DATA_W,
    parameter int NUM_REGS = CPU_NUM_REGS,
    parameter int ADDR_W   = CPU_ADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [ADDR_W-1:0]   waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [ADDR_W-1:0]   raddr_a,
    input  logic [ADDR_W-1:0]   raddr_b,
    output logic [DATA_W-1:0]   rdata_a,
    output logic [DATA_W-1:0]   rdata_b,
    output logic [WR_CNT_W-1:0] wr_count
);

    function automatic logic [WR_CNT_W-1:0] sat_inc(input logic [WR_CNT_W-1:0] v);
        return (v == WR_CNT_MAX) ? v : v + WR_CNT_W'(1);
    endfunction

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [WR_CNT_W-1:0] r_wr_count;

    logic w_commit;
    logic w_byp_a;
    logic w_byp_b;

    // Reset blocks both the write and the bypass, so a reset cycle shows stored values.
    assign w_commit = we && !reset && (waddr != '0);
    assign w_byp_a  = w_commit && (raddr_a == waddr);
    assign w_byp_b  = w_commit && (raddr_b == waddr);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_count <= '0;
        end else if (w_commit) begin
            r_regs[waddr] <= wdata;
            r_wr_count    <= sat_inc(r_wr_count);
        end
    end

    // The explicit zero for r0 keeps the output free of X even before the first reset.
    assign rdata_a  = w_byp_a ? wdata : ((raddr_a == '0) ? '0 : r_regs[raddr_a]);
    assign rdata_b  = w_byp_b ? wdata : ((raddr_b == '0) ? '0 : r_regs[raddr_b]);
    assign wr_count = r_wr_count;

endmodule

// File: tb/tb_register_file_16.sv
// Self-checking bench for register_file_16: directed scenarios plus randomized traffic
// compared every cycle against an array-based reference model.
module tb_register_file_16;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [2:0]  waddr;
    logic [15:0] wdata;
    logic [2:0]  raddr_a;
    logic [2:0]  raddr_b;
    logic [15:0] rdata_a;
    logic [15:0] rdata_b;
    logic [7:0]  wr_count;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [15:0] mdl_mem [8];
    int          mdl_cnt;

    register_file_16 dut (
        .clk      (clk),
        .reset    (reset),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr_a  (raddr_a),
        .raddr_b  (raddr_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .wr_count (wr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an array of registers, a saturating counter and the write-before-read rule.
    function automatic int model_read(input logic [2:0] ra);
        if (we && !reset && waddr != 0 && ra == waddr) return int'(wdata);
        if (ra == 0) return 0;
        return int'(mdl_mem[ra]);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) mdl_mem[i] = 16'h0;
            mdl_cnt = 0;
        end else if (we && waddr != 0) begin
            mdl_mem[waddr] = wdata;
            mdl_cnt = (mdl_cnt >= 255) ? 255 : mdl_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_rdata_a", int'(rdata_a), model_read(raddr_a));
            check("model_rdata_b", int'(rdata_b), model_read(raddr_b));
            check("model_wr_count", int'(wr_count), mdl_cnt);
        end
    end

    task automatic drive(input logic rst, input logic w, input logic [2:0] wa,
                         input logic [15:0] wd, input logic [2:0] ra, input logic [2:0] rb);
        @(posedge clk);
        #1;
        reset = rst; we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
    endtask

    task automatic settle;
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        drive(1, 0, 0, 16'h0, 0, 0);

        // All addresses read zero after reset on both ports.
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 16'h0, 3'(i), 3'(7 - i));
            settle;
            check("reset_rdata_a", int'(rdata_a), 0);
            check("reset_rdata_b", int'(rdata_b), 0);
        end
        check("reset_wr_count", int'(wr_count), 0);

        // Write r3, read it on both ports next cycle.
        drive(0, 1, 3, 16'hBEEF, 0, 0);
        drive(0, 0, 0, 16'h0, 3, 3);
        settle;
        check("r3_port_a", int'(rdata_a), 16'hBEEF);
        check("r3_port_b", int'(rdata_b), 16'hBEEF);
        check("r3_wr_count", int'(wr_count), 1);

        // Writes to r0 are discarded and not counted.
        drive(0, 1, 0, 16'h1234, 0, 0);
        settle;
        check("r0_same_cycle", int'(rdata_a), 0);
        drive(0, 0, 0, 16'h0, 0, 0);
        settle;
        check("r0_next_cycle", int'(rdata_a), 0);
        check("r0_wr_count", int'(wr_count), 1);

        // Bypass on port B over a stored value.
        drive(0, 1, 5, 16'h1111, 0, 0);
        drive(0, 1, 5, 16'hA5A5, 5, 5);
        settle;
        check("bypass_same_a", int'(rdata_a), 16'hA5A5);
        check("bypass_same_b", int'(rdata_b), 16'hA5A5);
        drive(0, 0, 0, 16'h0, 0, 5);
        settle;
        check("bypass_after_b", int'(rdata_b), 16'hA5A5);
        check("bypass_wr_count", int'(wr_count), 3);

        // Reset beats a concurrent write, and bypass is suppressed during reset.
        drive(1, 1, 2, 16'hFFFF, 2, 5);
        settle;
        check("rst_no_bypass_a", int'(rdata_a), 0);
        drive(0, 0, 0, 16'h0, 2, 5);
        settle;
        check("rst_r2_cleared", int'(rdata_a), 0);
        check("rst_r5_cleared", int'(rdata_b), 0);
        check("rst_wr_count", int'(wr_count), 0);

        // Randomized traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            drive(($urandom_range(0, 63) == 0), $urandom_range(0, 1) == 1,
                  3'($urandom_range(0, 7)), 16'($urandom), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)));
        end

        // Counter saturation: 300 writes to r7.
        drive(1, 0, 0, 16'h0, 0, 0);
        for (int n = 1; n <= 300; n++) begin
            drive(0, 1, 7, 16'(n), 7, 3'($urandom_range(0, 7)));
            if (n == 255) begin
                settle;
                check("cnt_before_255", int'(wr_count), 254);
            end
        end
        drive(0, 0, 0, 16'h0, 7, 7);
        settle;
        check("sat_wr_count", int'(wr_count), 255);
        check("sat_r7_a", int'(rdata_a), 300);
        check("sat_r7_b", int'(rdata_b), 300);

        drive(0, 0, 0, 16'h0, 0, 0);
        settle;
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
